// File: rtl/alu_core_32_pkg.sv
// Shared opcode encoding and result width for the Mini-SRC ALU datapath.
package alu_pkg;

    localparam int RESULT_W = 64;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_ROR = 4'b0010,
        OP_ROL = 4'b0011,
        OP_SHR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_AND = 4'b0110,
        OP_OR  = 4'b0111,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001,
        OP_NEG = 4'b1010,
        OP_NOT = 4'b1011
    } alu_op_e;

endpackage

// File: rtl/alu_core_32_if.sv
// Operand/opcode/result bundle between the datapath control and the ALU.
// There is no handshake: operands are sampled on every rising clock edge and
// the result is valid one cycle later, every cycle.
interface alu_core_32_if;
    import alu_pkg::*;

    logic [31:0]         in_a;
    logic [31:0]         in_b;
    logic [3:0]          in_opcode;
    logic [RESULT_W-1:0] out_result;

    modport master (output in_a, output in_b, output in_opcode, input out_result);
    modport slave  (input in_a, input in_b, input in_opcode, output out_result);
endinterface

// File: rtl/adder_32.sv
// 32-bit adder with carry-in/carry-out, shared by ADD, SUB, NEG and NOT.
module adder_32 (
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic        in_carry,
    output logic [31:0] out_sum,
    output logic        out_carry
);
    assign {out_carry, out_sum} = {1'b0, in_x} + {1'b0, in_y} + {32'd0, in_carry};
endmodule

// File: rtl/multiplier_32.sv
// Signed 32x32 -> 64 multiplier using radix-4 Booth recoding of in_y.
module multiplier_32 (
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    output logic [63:0] out_product
);
    logic [63:0] x_ext;
    logic [32:0] y_pad;
    logic [63:0] pp;
    logic [63:0] acc;

    always_comb begin
        x_ext = {{32{in_x[31]}}, in_x};
        y_pad = {in_y, 1'b0};
        acc   = '0;
        pp    = '0;
        // Each overlapping triplet selects 0, +-x or +-2x weighted by 4^i.
        for (int i = 0; i < 16; i++) begin
            case (y_pad[2*i+2 -: 3])
                3'b001, 3'b010: pp = x_ext;
                3'b011:         pp = x_ext << 1;
                3'b100:         pp = ~(x_ext << 1) + 64'd1;
                3'b101, 3'b110: pp = ~x_ext + 64'd1;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        out_product = acc;
    end
endmodule

// File: rtl/shift_rot_32.sv
// Five-stage logarithmic barrel shifter/rotator; amount range 0-31.
module shift_rot_32 (
    input  logic [31:0] in_x,
    input  logic [4:0]  in_y,
    input  logic        in_left,
    input  logic        in_rot,
    output logic [31:0] out
);
    logic [31:0] stage;

    always_comb begin
        stage = in_x;
        for (int k = 0; k < 5; k++) begin
            if (in_y[k]) begin
                if (in_left) begin
                    stage = in_rot ? ((stage << (1 << k)) | (stage >> (32 - (1 << k))))
                                   : (stage << (1 << k));
                end else begin
                    stage = in_rot ? ((stage >> (1 << k)) | (stage << (32 - (1 << k))))
                                   : (stage >> (1 << k));
                end
            end
        end
        out = stage;
    end
endmodule

// File: rtl/alu_core_32.sv
// Registered 32-bit ALU: adder, barrel shifter and signed multiplier behind a
// 4-bit opcode, producing a 64-bit HI/LO result one clock later.
module alu_core_32
    import alu_pkg::*;
(
    input  logic          in_clk,
    input  logic          in_reset_n,
    alu_core_32_if.slave  bus
);
    logic [31:0]         add_x;
    logic [31:0]         add_y;
    logic                add_cin;
    logic [31:0]         add_sum;
    logic                unused_add_cout;
    logic [31:0]         shift_out;
    logic [63:0]         mul_out;
    logic [RESULT_W-1:0] result_d;
    logic [RESULT_W-1:0] result_q;

    // NEG/NOT reuse the adder as 0 + ~B + cin.
    always_comb begin
        add_x   = (bus.in_opcode == OP_NEG || bus.in_opcode == OP_NOT) ? 32'd0 : bus.in_a;
        add_y   = (bus.in_opcode == OP_SUB || bus.in_opcode == OP_NEG ||
                   bus.in_opcode == OP_NOT) ? ~bus.in_b : bus.in_b;
        add_cin = (bus.in_opcode == OP_SUB || bus.in_opcode == OP_NEG);
    end

    adder_32 u_adder (
        .in_x      (add_x),
        .in_y      (add_y),
        .in_carry  (add_cin),
        .out_sum   (add_sum),
        .out_carry (unused_add_cout)
    );

    shift_rot_32 u_shift (
        .in_x    (bus.in_a),
        .in_y    (bus.in_b[4:0]),
        .in_left (bus.in_opcode[0]),
        .in_rot  (bus.in_opcode[1]),
        .out     (shift_out)
    );

    multiplier_32 u_mul (
        .in_x        (bus.in_a),
        .in_y        (bus.in_b),
        .out_product (mul_out)
    );

    always_comb begin
        result_d = '0;
        case (bus.in_opcode)
            OP_ADD, OP_SUB, OP_NEG, OP_NOT: result_d = {32'd0, add_sum};
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: result_d = {32'd0, shift_out};
            OP_AND:                         result_d = {32'd0, bus.in_a & bus.in_b};
            OP_OR:                          result_d = {32'd0, bus.in_a | bus.in_b};
            OP_MUL:                         result_d = mul_out;
            default:                        result_d = '0;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.out_result = result_q;
endmodule

// File: tb/tb_alu_core_32.sv
// Bench for alu_core_32: directed vectors, reset behaviour and random ops
// against an arithmetic reference model.
module tb_alu_core_32;
    import alu_pkg::*;

    logic in_clk;
    logic in_reset_n;
    int   n_checks;
    int   n_errors;

    logic [63:0] exp_q[$];
    string       tag_q[$];

    alu_core_32_if bus ();

    alu_core_32 dut (
        .in_clk     (in_clk),
        .in_reset_n (in_reset_n),
        .bus        (bus)
    );

    // clock / reset
    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %016h expected %016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned n;
        logic [63:0] dbl;
        logic [63:0] tmp;
        longint      sa;
        longint      sb;
        n   = b % 32;
        dbl = {a, a};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        tmp = 64'd0;
        case (op)
            4'd0:  tmp = {32'd0, a + b};
            4'd1:  tmp = {32'd0, a - b};
            4'd2:  tmp = {32'd0, 32'(dbl >> n)};
            4'd3:  tmp = (dbl << n) >> 32;
            4'd4:  tmp = {32'd0, a >> n};
            4'd5:  tmp = {32'd0, a << n};
            4'd6:  tmp = {32'd0, a & b};
            4'd7:  tmp = {32'd0, a | b};
            4'd8:  tmp = 64'(sa * sb);
            4'd10: tmp = {32'd0, 32'd0 - b};
            4'd11: tmp = {32'd0, ~b};
            default: tmp = 64'd0;
        endcase
        return tmp;
    endfunction

    task automatic compare_pending();
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), bus.out_result, exp_q.pop_front());
        end
    endtask

    // Drive at the falling edge; the previous op's result is checked first.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
        @(negedge in_clk);
        compare_pending();
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic flush();
        @(negedge in_clk);
        compare_pending();
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_checks      = 0;
        n_errors      = 0;
        in_reset_n    = 1'b1;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_opcode = OP_ADD;
        #1 in_reset_n = 1'b0;
        #2 check("rst_init", bus.out_result, 64'd0);
        repeat (2) @(posedge in_clk);
        #1 check("rst_hold", bus.out_result, 64'd0);
        @(negedge in_clk);
        in_reset_n = 1'b1;
        exp_q.push_back(64'd0);
        tag_q.push_back("post_rst_add0");

        apply(OP_NOT, 32'hF0F0F0F0, 32'hABCDABCD, 64'h00000000_54325432, "not");
        apply(OP_AND, 32'hFFFFFFFF, 32'h0F0F0F0F, 64'h00000000_0F0F0F0F, "and");
        apply(OP_OR,  32'hF0F0F0F0, 32'h0F0F0F0F, 64'h00000000_FFFFFFFF, "or");
        apply(OP_ADD, 32'h0000FFFF, 32'h00000001, 64'h00000000_00010000, "add");
        apply(OP_SUB, 32'h0000FFFF, 32'h000000FF, 64'h00000000_0000FF00, "sub");
        apply(OP_NEG, 32'h00000001, 32'h00000001, 64'h00000000_FFFFFFFF, "neg");
        apply(OP_MUL, 32'hFFFFFFF3, 32'h0000000B, 64'hFFFFFFFF_FFFFFF71, "mul_neg");
        apply(OP_MUL, 32'h7FFFFFFF, 32'h00000002, 64'h00000000_FFFFFFFE, "mul_pos");
        apply(OP_ROR, 32'h80000001, 32'h00000004, 64'h00000000_18000000, "ror4");
        apply(OP_ROL, 32'h80000001, 32'h00000004, 64'h00000000_00000018, "rol4");
        apply(OP_SHR, 32'h80000001, 32'h00000004, 64'h00000000_08000000, "shr4");
        apply(OP_SHL, 32'h80000001, 32'h00000004, 64'h00000000_00000010, "shl4");
        apply(OP_SHL, 32'h80000001, 32'h00000024, 64'h00000000_00000010, "shl_hi_b");
        apply(OP_ROR, 32'h80000001, 32'h00000024, 64'h00000000_18000000, "ror_hi_b");
        apply(OP_ROL, 32'h80000001, 32'h00000020, 64'h00000000_80000001, "rol0");
        apply(OP_SHR, 32'h80000001, 32'h0000001F, 64'h00000000_00000001, "shr31");
        apply(OP_ROL, 32'h80000001, 32'h0000001F, 64'h00000000_C0000000, "rol31");
        apply(OP_DIV, 32'h0000000A, 32'hFFFFFFFD, 64'd0, "div");
        apply(4'hF,   32'h12345678, 32'h9ABCDEF0, 64'd0, "op_f");
        apply(OP_MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mul_min");

        // Asynchronous reset mid-cycle discards the captured and in-flight ops.
        apply(OP_ADD, 32'h00000001, 32'h00000001, 64'd2, "pre_rst");
        flush();
        apply(OP_ADD, 32'h00000005, 32'h00000006, 64'd11, "in_flight");
        @(posedge in_clk);
        #2 in_reset_n = 1'b0;
        #1 check("async_rst", bus.out_result, 64'd0);
        exp_q.delete();
        tag_q.delete();
        @(posedge in_clk);
        #1 check("rst_hold2", bus.out_result, 64'd0);
        @(negedge in_clk);
        in_reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            apply(op, a, b, ref_model(op, a, b), $sformatf("rand_op%0d", op));
        end
        flush();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_core_32.md
# alu_core_32

Registered 32-bit integer ALU datapath for the Mini-SRC CPU. It combines a ripple/carry adder, a barrel shifter/rotator and a signed multiplier behind a 4-bit opcode. It produces a 64-bit result one clock after operands are presented. The result feeds the Z (HI/LO) register path of the datapath.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit result.
- One clock; reset is asynchronous and active-low.
- in_clk  input  1  rising-edge clock.
- in_reset_n  input  1  asynchronous active-low reset.
- in_a  input  32  operand A.
- in_b  input  32  operand B; it is also the shift/rotate amount source.
- in_opcode  input  4  operation select.
- out_result  output  64  registered result; bits [63:32] are HI and bits [31:0] are LO.

## Operation
- Opcodes:
  - 0000 ADD: LO = (A + B) mod 2^32.
  - 0001 SUB: LO = A + ~B + 1.
  - 0010 ROR: rotate right.
  - 0011 ROL: rotate left.
  - 0100 SHR: shift right.
  - 0101 SHL: shift left.
  - 0110 AND: LO = A & B.
  - 0111 OR: LO = A | B.
  - 1000 MUL: full 64-bit product.
  - 1001 DIV: reserved.
  - 1010 NEG: LO = 0 + ~B + 1, i.e. two's-complement negate of B.
  - 1011 NOT: LO = 0 + ~B + 0, i.e. bitwise invert of B.
  - 1100–1111: unused.
- ADD, SUB, NEG and NOT share one 32-bit adder.
  - Adder X input is forced to 0 for NEG and NOT, otherwise it is A.
  - Adder Y input is ~B for SUB, NEG and NOT, otherwise it is B.
  - Carry-in is 1 for SUB and NEG, otherwise 0.
  - Adder carry-out is discarded. There are no flags.
- All 32-bit results are zero-extended: HI = 0.
- Shifts and rotates:
  - Amount = B[4:0], range 0–31. B[31:5] is ignored.
  - Amount 0 passes A unchanged.
  - SHR is logical, zero-filling from the MSB. SHL zero-fills from the LSB.
  - Rotates wrap modulo 32.
  - The shifter is steered by opcode bit 0 (1 = left) and bit 1 (1 = rotate).
- MUL: signed two's-complement A × B, exact 64-bit result with HI = upper half.
- DIV (1001) and unused opcodes (1100–1111) produce 64'h0. Division is implemented in a separate block.

## Timing
- Fully combinational compute between the input pins and the output register.
- out_result is updated on every rising in_clk edge from the values of in_a, in_b and in_opcode at that edge. Latency is 1 cycle.
- There is no handshake and no enable. A new operation can be issued every cycle, with throughput of 1 per clock.
- Asserting in_reset_n low clears out_result to 0 immediately, independent of the clock.
- While in_reset_n is held low, out_result stays 0.
- The first capture happens on the first rising edge after deassertion.
- An operation in flight when reset asserts is lost; no partial result is ever visible.
- Operand or opcode changes between edges have no effect on out_result until the next edge.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit opcode constants (OP_ADD … OP_NOT),
  - the result width constant (64).
- Three combinational sub-modules are instantiated in this block:
  - adder_32: ports in_x, in_y, in_carry, out_sum, out_carry.
  - shift_rot_32: ports in_x, in_y, in_left, in_rot, out.
  - multiplier_32: ports in_x, in_y, out_product (signed, 64-bit; Booth recoding recommended).
- The top level contains:
  - operand pre-processing (adder input forcing, B inversion, carry-in select),
  - the AND/OR logic,
  - the result mux,
  - the single 64-bit output register.

## Test plan
Each result is checked one cycle after the operands are applied.
- Reset:
  - With in_reset_n low mid-cycle, out_result = 0 asynchronously.
  - After release, with A=0, B=0 and opcode ADD, out_result = 0.
- Logic and NOT:
  - NOT, A=F0F0F0F0, B=ABCDABCD → 00000000_54325432.
  - AND, A=FFFFFFFF, B=0F0F0F0F → 00000000_0F0F0F0F.
  - OR, A=F0F0F0F0, B=0F0F0F0F → 00000000_FFFFFFFF.
- Arithmetic:
  - ADD, A=0000FFFF, B=1 → 00000000_00010000.
  - SUB, A=0000FFFF, B=FF → 00000000_0000FF00.
  - NEG, A=1, B=1 → 00000000_FFFFFFFF.
- MUL:
  - A=FFFFFFF3 (−13), B=0000000B → FFFFFFFF_FFFFFF71 (−143).
  - A=7FFFFFFF, B=2 → 00000000_FFFFFFFE.
- Shift/rotate:
  - A=80000001, B=4 gives:
    - ROR → 00000000_18000000.
    - ROL → 00000000_00000018.
    - SHR → 00000000_08000000.
    - SHL → 00000000_00000010.
  - B=0000_0024 uses amount 4 (upper bits of B ignored).
- Reserved and unused opcodes:
  - DIV with A=0A, B=FFFFFFFD → 0.
  - Opcode 1111 → 0.
  - Back-to-back opcode changes on consecutive cycles each show their own result one cycle later.
